// File: rtl/des_pkg.sv
// Shared DES constants for the substitution engine: the eight S-box tables,
// the P permutation table, FSM state encodings and the P permutation helper.
package des_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_BUSY = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Indexed as SBOX[box][row][column], box 0 is S1.
   localparam logic [3:0] SBOX [8][4][16] = '{
      '{'{4'hE,4'h4,4'hD,4'h1,4'h2,4'hF,4'hB,4'h8,4'h3,4'hA,4'h6,4'hC,4'h5,4'h9,4'h0,4'h7},
        '{4'h0,4'hF,4'h7,4'h4,4'hE,4'h2,4'hD,4'h1,4'hA,4'h6,4'hC,4'hB,4'h9,4'h5,4'h3,4'h8},
        '{4'h4,4'h1,4'hE,4'h8,4'hD,4'h6,4'h2,4'hB,4'hF,4'hC,4'h9,4'h7,4'h3,4'hA,4'h5,4'h0},
        '{4'hF,4'hC,4'h8,4'h2,4'h4,4'h9,4'h1,4'h7,4'h5,4'hB,4'h3,4'hE,4'hA,4'h0,4'h6,4'hD}},
      '{'{4'hF,4'h1,4'h8,4'hE,4'h6,4'hB,4'h3,4'h4,4'h9,4'h7,4'h2,4'hD,4'hC,4'h0,4'h5,4'hA},
        '{4'h3,4'hD,4'h4,4'h7,4'hF,4'h2,4'h8,4'hE,4'hC,4'h0,4'h1,4'hA,4'h6,4'h9,4'hB,4'h5},
        '{4'h0,4'hE,4'h7,4'hB,4'hA,4'h4,4'hD,4'h1,4'h5,4'h8,4'hC,4'h6,4'h9,4'h3,4'h2,4'hF},
        '{4'hD,4'h8,4'hA,4'h1,4'h3,4'hF,4'h4,4'h2,4'hB,4'h6,4'h7,4'hC,4'h0,4'h5,4'hE,4'h9}},
      '{'{4'hA,4'h0,4'h9,4'hE,4'h6,4'h3,4'hF,4'h5,4'h1,4'hD,4'hC,4'h7,4'hB,4'h4,4'h2,4'h8},
        '{4'hD,4'h7,4'h0,4'h9,4'h3,4'h4,4'h6,4'hA,4'h2,4'h8,4'h5,4'hE,4'hC,4'hB,4'hF,4'h1},
        '{4'hD,4'h6,4'h4,4'h9,4'h8,4'hF,4'h3,4'h0,4'hB,4'h1,4'h2,4'hC,4'h5,4'hA,4'hE,4'h7},
        '{4'h1,4'hA,4'hD,4'h0,4'h6,4'h9,4'h8,4'h7,4'h4,4'hF,4'hE,4'h3,4'hB,4'h5,4'h2,4'hC}},
      '{'{4'h7,4'hD,4'hE,4'h3,4'h0,4'h6,4'h9,4'hA,4'h1,4'h2,4'h8,4'h5,4'hB,4'hC,4'h4,4'hF},
        '{4'hD,4'h8,4'hB,4'h5,4'h6,4'hF,4'h0,4'h3,4'h4,4'h7,4'h2,4'hC,4'h1,4'hA,4'hE,4'h9},
        '{4'hA,4'h6,4'h9,4'h0,4'hC,4'hB,4'h7,4'hD,4'hF,4'h1,4'h3,4'hE,4'h5,4'h2,4'h8,4'h4},
        '{4'h3,4'hF,4'h0,4'h6,4'hA,4'h1,4'hD,4'h8,4'h9,4'h4,4'h5,4'hB,4'hC,4'h7,4'h2,4'hE}},
      '{'{4'h2,4'hC,4'h4,4'h1,4'h7,4'hA,4'hB,4'h6,4'h8,4'h5,4'h3,4'hF,4'hD,4'h0,4'hE,4'h9},
        '{4'hE,4'hB,4'h2,4'hC,4'h4,4'h7,4'hD,4'h1,4'h5,4'h0,4'hF,4'hA,4'h3,4'h9,4'h8,4'h6},
        '{4'h4,4'h2,4'h1,4'hB,4'hA,4'hD,4'h7,4'h8,4'hF,4'h9,4'hC,4'h5,4'h6,4'h3,4'h0,4'hE},
        '{4'hB,4'h8,4'hC,4'h7,4'h1,4'hE,4'h2,4'hD,4'h6,4'hF,4'h0,4'h9,4'hA,4'h4,4'h5,4'h3}},
      '{'{4'hC,4'h1,4'hA,4'hF,4'h9,4'h2,4'h6,4'h8,4'h0,4'hD,4'h3,4'h4,4'hE,4'h7,4'h5,4'hB},
        '{4'hA,4'hF,4'h4,4'h2,4'h7,4'hC,4'h9,4'h5,4'h6,4'h1,4'hD,4'hE,4'h0,4'hB,4'h3,4'h8},
        '{4'h9,4'hE,4'hF,4'h5,4'h2,4'h8,4'hC,4'h3,4'h7,4'h0,4'h4,4'hA,4'h1,4'hD,4'hB,4'h6},
        '{4'h4,4'h3,4'h2,4'hC,4'h9,4'h5,4'hF,4'hA,4'hB,4'hE,4'h1,4'h7,4'h6,4'h0,4'h8,4'hD}},
      '{'{4'h4,4'hB,4'h2,4'hE,4'hF,4'h0,4'h8,4'hD,4'h3,4'hC,4'h9,4'h7,4'h5,4'hA,4'h6,4'h1},
        '{4'hD,4'h0,4'hB,4'h7,4'h4,4'h9,4'h1,4'hA,4'hE,4'h3,4'h5,4'hC,4'h2,4'hF,4'h8,4'h6},
        '{4'h1,4'h4,4'hB,4'hD,4'hC,4'h3,4'h7,4'hE,4'hA,4'hF,4'h6,4'h8,4'h0,4'h5,4'h9,4'h2},
        '{4'h6,4'hB,4'hD,4'h8,4'h1,4'h4,4'hA,4'h7,4'h9,4'h5,4'h0,4'hF,4'hE,4'h2,4'h3,4'hC}},
      '{'{4'hD,4'h2,4'h8,4'h4,4'h6,4'hF,4'hB,4'h1,4'hA,4'h9,4'h3,4'hE,4'h5,4'h0,4'hC,4'h7},
        '{4'h1,4'hF,4'hD,4'h8,4'hA,4'h3,4'h7,4'h4,4'hC,4'h5,4'h6,4'hB,4'h0,4'hE,4'h9,4'h2},
        '{4'h7,4'hB,4'h4,4'h1,4'h9,4'hC,4'hE,4'h2,4'h0,4'h6,4'hA,4'hD,4'hF,4'h3,4'h5,4'h8},
        '{4'h2,4'h1,4'hE,4'h7,4'h4,4'hA,4'h8,4'hD,4'hF,4'hC,4'h9,4'h0,4'h3,4'h5,4'h6,4'hB}}
   };

   // Output bit i (1 = MSB) takes input bit P_TAB[i-1] (1 = MSB).
   localparam logic [5:0] P_TAB [32] = '{
      6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
      6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
      6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
      6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
   };

   function automatic logic [31:0] p_permute(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) begin
         y[31-i] = x[32-int'(P_TAB[i])];
      end
      return y;
   endfunction

endpackage

// File: rtl/sbox_lut.sv
// Single DES S-box lookup: sel picks the box (0 = S1), row = {b5,b0}, column = b4..b1.
module sbox_lut
   import des_pkg::*;
(
   input  logic [2:0] sel,
   input  logic [5:0] in_6bit,
   output logic [3:0] out_4bit
);

   assign out_4bit = SBOX[sel][{in_6bit[5], in_6bit[0]}][in_6bit[4:1]];

endmodule

// File: rtl/sbox_sub_engine.sv
// DES S-box substitution engine: LANES lookups per cycle over 8/LANES passes.
// Define SBOX_PERM_EN to apply the DES P permutation to the finished word.
module sbox_sub_engine
   import des_pkg::*;
#(
   parameter int LANES = 8
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [47:0] in_block,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   localparam int PASSES = 8 / LANES;
   localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;

   state_t        state_q, state_d;
   logic [PW-1:0] pass_q, pass_d;
   logic [47:0]   blk_q, blk_d;
   logic [31:0]   res_q, res_d;
   logic [3:0]    lane_out [LANES];
   logic [31:0]   merged;
   logic [31:0]   final_word;
   logic          last_pass;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [2:0]  sel;
      logic [47:0] blk_sh;
      // Box s reads in_block[47-6s -: 6]; shifting left brings it to the top.
      assign sel    = 3'(int'(pass_q) * LANES + l);
      assign blk_sh = blk_q << (6 * int'(sel));
      sbox_lut u_lut (
         .sel      (sel),
         .in_6bit  (blk_sh[47:42]),
         .out_4bit (lane_out[l])
      );
   end

   always_comb begin
      merged = res_q;
      for (int l = 0; l < LANES; l++) begin
         merged = (merged & ~(32'hF000_0000 >> (4 * (int'(pass_q) * LANES + l))))
                | ({lane_out[l], 28'd0} >> (4 * (int'(pass_q) * LANES + l)));
      end
   end

   assign last_pass = (pass_q == PW'(PASSES - 1));

`ifdef SBOX_PERM_EN
   assign final_word = p_permute(merged);
`else
   assign final_word = merged;
`endif

   always_comb begin
      state_d = state_q;
      pass_d  = pass_q;
      blk_d   = blk_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               blk_d   = in_block;
               pass_d  = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (last_pass) begin
               res_d   = final_word;
               pass_d  = '0;
               state_d = ST_DONE;
            end else begin
               res_d  = merged;
               pass_d = pass_q + PW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
         pass_q  <= '0;
         blk_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
         blk_q   <= blk_d;
         res_q   <= res_d;
      end
   end

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign out_word  = res_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sbox_sub_engine.sv
// Bench for sbox_sub_engine: four instances (LANES 1/2/4/8) checked against an
// independent S-box/P model through an expected-value queue.
module tb_sbox_sub_engine;

   logic        clk;
   logic        n_rst     [4];
   logic        in_valid  [4];
   logic        in_ready  [4];
   logic [47:0] in_block  [4];
   logic        out_valid [4];
   logic        out_ready [4];
   logic [31:0] out_word  [4];
   logic        busy      [4];
   logic [1:0]  dbg_state [4];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int acc_cyc [4];
   logic ov_prev [4];
   logic [31:0] exp_q [$];

   logic [255:0] ref_tab [8];
   int p_tab [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                      2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sbox_sub_engine #(.LANES(1 << g)) u_dut (
         .clk       (clk),
         .n_rst     (n_rst[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_block  (in_block[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_word  (out_word[g]),
         .busy      (busy[g]),
         .dbg_state (dbg_state[g])
      );
   end

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_sub(input logic [47:0] blk);
      logic [31:0] r;
      logic [5:0]  grp;
      int          e;
      r = '0;
      for (int s = 0; s < 8; s++) begin
         grp = blk[47 - 6*s -: 6];
         e = int'({grp[5], grp[0]}) * 16 + int'(grp[4:1]);
         r[31 - 4*s -: 4] = ref_tab[s][255 - 4*e -: 4];
      end
      return r;
   endfunction

   function automatic logic [31:0] ref_perm(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) y[31-i] = x[32 - p_tab[i]];
      return y;
   endfunction

   function automatic logic [31:0] exp_word(input logic [47:0] blk);
`ifdef SBOX_PERM_EN
      return ref_perm(ref_sub(blk));
`else
      return ref_sub(blk);
`endif
   endfunction

   task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [31:0] w;
      for (int k = 0; k < 4; k++) begin
         if (in_valid[k] && in_ready[k] && n_rst[k]) begin
            exp_q.push_back(exp_word(in_block[k]));
            acc_cyc[k] = cyc + 1;
         end
         if (out_valid[k] === 1'b1 && ov_prev[k] !== 1'b1)
            check("latency", 48'(cyc - acc_cyc[k]), 48'(8 >> k));
         if (out_valid[k] && out_ready[k]) begin
            check("sb_nonempty", 48'(exp_q.size() != 0), 48'd1);
            if (exp_q.size() != 0) begin
               w = exp_q.pop_front();
               check("sb_word", 48'(out_word[k]), 48'(w));
            end
         end
         ov_prev[k] = out_valid[k];
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input int k, input logic [47:0] blk);
      int n;
      in_block[k] = blk;
      in_valid[k] = 1'b1;
      for (n = 0; n < 40; n++) begin
         @(negedge clk);
         if (in_ready[k]) break;
      end
      if (n == 40) check("accept_timeout", 48'(in_ready[k]), 48'd1);
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
   endtask

   task automatic wait_out(input int k);
      int n;
      for (n = 0; n < 40; n++) begin
         @(negedge clk);
         if (out_valid[k]) break;
      end
      if (n == 40) check("out_timeout", 48'(out_valid[k]), 48'd1);
   endtask

   task automatic drain(input int k, input int stall);
      wait_out(k);
      @(posedge clk); #1;
      repeat (stall) begin
         @(posedge clk); #1;
      end
      out_ready[k] = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
      check("post_hs_valid", 48'(out_valid[k]), 48'd0);
      check("post_hs_ready", 48'(in_ready[k]), 48'd1);
   endtask

   task automatic check_reset_outputs(input int k);
      check("rst_in_ready",  48'(in_ready[k]),  48'd1);
      check("rst_out_valid", 48'(out_valid[k]), 48'd0);
      check("rst_busy",      48'(busy[k]),      48'd0);
      check("rst_out_word",  48'(out_word[k]),  48'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] want, r0, r1;
      logic [47:0] blk_a, blk_b;

      ref_tab[0] = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
      ref_tab[1] = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
      ref_tab[2] = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
      ref_tab[3] = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
      ref_tab[4] = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
      ref_tab[5] = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
      ref_tab[6] = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
      ref_tab[7] = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

      for (int k = 0; k < 4; k++) begin
         n_rst[k]     = 1'b0;
         in_valid[k]  = 1'b0;
         in_block[k]  = '0;
         out_ready[k] = 1'b0;
         acc_cyc[k]   = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) check_reset_outputs(k);
      for (int k = 0; k < 4; k++) n_rst[k] = 1'b1;
      @(posedge clk); #1;

      // All-zero block, LANES=8: one compute cycle.
      send(3, 48'h0);
      wait_out(3);
`ifdef SBOX_PERM_EN
      want = ref_perm(32'hEFA72C4D);
`else
      want = 32'hEFA72C4D;
`endif
      check("vec_zero_l8", 48'(out_word[3]), 48'(want));
      drain(3, 0);

      // All-ones block, LANES=1: eight compute cycles.
      send(0, 48'hFFFF_FFFF_FFFF);
      wait_out(0);
`ifdef SBOX_PERM_EN
      want = ref_perm(32'hD9CE3DCB);
`else
      want = 32'hD9CE3DCB;
`endif
      check("vec_ones_l1", 48'(out_word[0]), 48'(want));
      drain(0, 0);

      // Backpressure in DONE with a second block already waiting, LANES=4.
      blk_a = 48'h1234_5678_9ABC;
      blk_b = 48'hFEDC_BA98_7654;
      in_block[2] = blk_a;
      in_valid[2] = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      in_block[2] = blk_b;
      wait_out(2);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("stall_word",  48'(out_word[2]),  48'(exp_word(blk_a)));
         check("stall_ready", 48'(in_ready[2]),  48'd0);
         check("stall_valid", 48'(out_valid[2]), 48'd1);
      end
      out_ready[2] = 1'b1;
      @(posedge clk); #1;
      out_ready[2] = 1'b0;
      check("hs_valid_drop", 48'(out_valid[2]), 48'd0);
      check("hs_ready_rise", 48'(in_ready[2]),  48'd1);
      @(posedge clk); #1;
      in_valid[2] = 1'b0;
      check("second_accept_busy", 48'(busy[2]), 48'd1);
      drain(2, 0);

      // Reset during BUSY pass 1, LANES=2.
      send(1, 48'hA5A5_5A5A_C3C3);
      @(posedge clk); #1;
      check("mid_busy", 48'(busy[1]), 48'd1);
      n_rst[1] = 1'b0;
      #1;
      check_reset_outputs(1);
      exp_q.delete();
      @(posedge clk); #1;
      n_rst[1] = 1'b1;
      out_ready[1] = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         check("no_stale_valid", 48'(out_valid[1]), 48'd0);
      end
      out_ready[1] = 1'b0;
      send(1, 48'h0F0F_F0F0_3C3C);
      drain(1, 1);

      // Random traffic on every lane configuration.
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 1000; i++) begin
            r0 = $urandom;
            r1 = $urandom;
            if (i == 0)      send(k, 48'h0);
            else if (i == 1) send(k, 48'hFFFF_FFFF_FFFF);
            else             send(k, {r0[15:0], r1});
            drain(k, $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk); #1;
            end
         end
      end

      check("sb_drained", 48'(exp_q.size()), 48'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
